// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: single-outstanding fetch, hold until retire, redirect and fault handling
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  input  logic        wb_update,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic [31:0] instret,
  output logic [1:0]  fault
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(TIMEOUT);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;
  logic [31:0]   instret_q, instret_d;
  logic [1:0]    fault_q, fault_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          redirect_misaligned;

  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      inst_pc_q <= RESET_PC;
      instret_q <= '0;
      fault_q   <= 2'b00;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        wait_d  = '0;
      end
      REQ: begin
        // A redirect takes priority and discards any data returned in the same cycle.
        if (redirect) begin
          if (redirect_misaligned) begin
            fault_d = 2'b01;
            state_d = HALT;
          end else begin
            pc_d   = redirect_pc;
            wait_d = '0;
          end
        end else if (imem_rdy) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_q + WW'(1) == TIMEOUT_W) begin
            fault_d = 2'b10;
            state_d = HALT;
          end
        end
      end
      HOLD: begin
        // Retirement counts even when a redirect in the same cycle picks the next pc.
        if (wb_update) begin
          instret_d = instret_q + 32'd1;
        end
        if (redirect) begin
          if (redirect_misaligned) begin
            fault_d = 2'b01;
            state_d = HALT;
          end else begin
            pc_d    = redirect_pc;
            wait_d  = '0;
            state_d = REQ;
          end
        end else if (wb_update) begin
          pc_d    = inst_pc_q + 32'd4;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = inst_pc_q + 32'd4;
  assign inst_valid = (state_q == HOLD);
  assign instret    = instret_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        wb_update = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [31:0] instret;
  logic [1:0]  fault;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.RESET_PC(32'h0100_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .wb_update(wb_update), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .instret(instret), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    imem_rdy = 1'b0; imem_rdata = 32'h0; wb_update = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  // Leaves the DUT in its first REQ cycle, sampled at a falling edge.
  task automatic reset_and_start();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %0b exp 0", imem_req); else passed++;
    total++; if (inst !== 32'h0000_0013) $display("FAIL rst_inst got %h exp 00000013", inst); else passed++;
    total++; if (inst_pc !== 32'h0100_0000) $display("FAIL rst_inst_pc got %h exp 01000000", inst_pc); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL rst_instret got %0d exp 0", instret); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL rst_fault got %b exp 00", fault); else passed++;
    @(negedge clk);
    rst = 1'b0;
    total++; if (imem_req !== 1'b0) $display("FAIL idle_req got %0b exp 0", imem_req); else passed++;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL first_req got %0b exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0100_0000) $display("FAIL first_addr got %h exp 01000000", imem_addr); else passed++;
    step();
    imem_rdy = 1'b1; imem_rdata = 32'h0020_0113;
    step();
    clear_inputs();
    total++; if (inst !== 32'h0020_0113) $display("FAIL fetch_inst got %h exp 00200113", inst); else passed++;
    total++; if (inst_pc !== 32'h0100_0000) $display("FAIL fetch_pc got %h exp 01000000", inst_pc); else passed++;
    total++; if (inst_valid !== 1'b1) $display("FAIL fetch_valid got %0b exp 1", inst_valid); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL hold_req got %0b exp 0", imem_req); else passed++;
    total++; if (pc_plus4 !== 32'h0100_0004) $display("FAIL pc_plus4 got %h exp 01000004", pc_plus4); else passed++;
  endtask

  task automatic test_retire();
    wb_update = 1'b1;
    step();
    clear_inputs();
    total++; if (imem_addr !== 32'h0100_0004) $display("FAIL retire_addr got %h exp 01000004", imem_addr); else passed++;
    total++; if (instret !== 32'd1) $display("FAIL retire_instret got %0d exp 1", instret); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL retire_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL retire_req got %0b exp 1", imem_req); else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    clear_inputs();
    total++; if (inst_pc !== 32'h0100_0004) $display("FAIL second_pc got %h exp 01000004", inst_pc); else passed++;
    total++; if (inst !== 32'h0030_0193) $display("FAIL second_inst got %h exp 00300193", inst); else passed++;
  endtask

  task automatic test_hold_stable();
    imem_rdy = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step();
    clear_inputs();
    total++; if (inst !== 32'h0030_0193) $display("FAIL hold_inst got %h exp 00300193", inst); else passed++;
    total++; if (inst_valid !== 1'b1) $display("FAIL hold_valid got %0b exp 1", inst_valid); else passed++;
    total++; if (instret !== 32'd1) $display("FAIL hold_instret got %0d exp 1", instret); else passed++;
  endtask

  task automatic test_redirect_wb();
    redirect = 1'b1; redirect_pc = 32'h0100_0040; wb_update = 1'b1;
    step();
    clear_inputs();
    total++; if (imem_addr !== 32'h0100_0040) $display("FAIL redir_wb_addr got %h exp 01000040", imem_addr); else passed++;
    total++; if (instret !== 32'd2) $display("FAIL redir_wb_instret got %0d exp 2", instret); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL redir_wb_req got %0b exp 1", imem_req); else passed++;
  endtask

  task automatic test_redirect_discard();
    redirect = 1'b1; redirect_pc = 32'h0100_0080; imem_rdy = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    clear_inputs();
    total++; if (inst_valid !== 1'b0) $display("FAIL discard_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (inst !== 32'h0030_0193) $display("FAIL discard_inst got %h exp 00300193", inst); else passed++;
    total++; if (imem_addr !== 32'h0100_0080) $display("FAIL discard_addr got %h exp 01000080", imem_addr); else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'hAAAA_0001;
    step();
    clear_inputs();
    total++; if (inst_pc !== 32'h0100_0080) $display("FAIL discard_fetch_pc got %h exp 01000080", inst_pc); else passed++;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    imem_rdy = 1'b1; imem_rdata = 32'h0000_0093;
    step();
    clear_inputs();
    total++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", inst_pc); else passed++;
    total++; if (pc_plus4 !== 32'h0000_0000) $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); else passed++;
    wb_update = 1'b1;
    step();
    clear_inputs();
    total++; if (imem_addr !== 32'h0000_0000) $display("FAIL wrap_addr got %h exp 00000000", imem_addr); else passed++;
    total++; if (instret !== 32'd3) $display("FAIL wrap_instret got %0d exp 3", instret); else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'h0000_0113;
    step();
    clear_inputs();
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'h0100_0042;
    step();
    clear_inputs();
    total++; if (fault !== 2'b01) $display("FAIL mis_fault got %b exp 01", fault); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL mis_req got %0b exp 0", imem_req); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL mis_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (imem_addr !== 32'h0000_0000) $display("FAIL mis_pc got %h exp 00000000", imem_addr); else passed++;
    imem_rdy = 1'b1; wb_update = 1'b1; redirect = 1'b1; redirect_pc = 32'h0100_0100;
    for (int i = 0; i < 4; i++) step();
    clear_inputs();
    total++; if (imem_req !== 1'b0) $display("FAIL halt_req got %0b exp 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0000_0000) $display("FAIL halt_pc got %h exp 00000000", imem_addr); else passed++;
    total++; if (instret !== 32'd3) $display("FAIL halt_instret got %0d exp 3", instret); else passed++;
    rst = 1'b1;
    #1;
    total++; if (fault !== 2'b00) $display("FAIL mis_rst_fault got %b exp 00", fault); else passed++;
  endtask

  task automatic test_timeout();
    reset_and_start();
    total++; if (imem_req !== 1'b1) $display("FAIL to_start_req got %0b exp 1", imem_req); else passed++;
    for (int i = 0; i < 15; i++) step();
    total++; if (imem_req !== 1'b1) $display("FAIL to_15_req got %0b exp 1", imem_req); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL to_15_fault got %b exp 00", fault); else passed++;
    step();
    total++; if (fault !== 2'b10) $display("FAIL to_fault got %b exp 10", fault); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL to_req got %0b exp 0", imem_req); else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'h0040_0213;
    for (int i = 0; i < 3; i++) step();
    clear_inputs();
    total++; if (inst_valid !== 1'b0) $display("FAIL to_late_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (inst !== 32'h0000_0013) $display("FAIL to_late_inst got %h exp 00000013", inst); else passed++;
    total++; if (fault !== 2'b10) $display("FAIL to_sticky got %b exp 10", fault); else passed++;
  endtask

  task automatic test_reset_abort();
    reset_and_start();
    imem_rdy = 1'b1; imem_rdata = 32'h0050_0293;
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (inst !== 32'h0000_0013) $display("FAIL abort_inst got %h exp 00000013", inst); else passed++;
    total++; if (inst_valid !== 1'b0) $display("FAIL abort_valid got %0b exp 0", inst_valid); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL abort_req got %0b exp 0", imem_req); else passed++;
    clear_inputs();
    rst = 1'b0;
    step();
    total++; if (imem_addr !== 32'h0100_0000) $display("FAIL abort_restart got %h exp 01000000", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL abort_restart_req got %0b exp 1", imem_req); else passed++;
  endtask

  initial begin
    test_reset();
    test_retire();
    test_hold_stable();
    test_redirect_wb();
    test_redirect_discard();
    test_wrap();
    test_misaligned();
    test_timeout();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
